// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, trap cause
// codes, bit positions inside mstatus/mie/mip and the redirect FSM states.
package csr_pkg;

  // CSR addresses (inst[31:20])
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Interrupt cause codes (mcause low bits)
  localparam int          CAUSE_W   = 4;
  localparam logic [3:0]  CAUSE_MTI = 4'd7;
  localparam logic [3:0]  CAUSE_MEI = 4'd11;

  // Bit positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIX_MTI_BIT      = 7;   // MTIE in mie, MTIP in mip
  localparam int MIX_MEI_BIT      = 11;  // MEIE in mie, MEIP in mip

  // Redirect FSM: REDIRECT covers the one-cycle refill bubble after a redirect
  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  // Byte offset of a vectored trap handler: 4 * cause
  function automatic logic [5:0] vec_offset(input logic [3:0] cause);
    return {cause, 2'b00};
  endfunction

endpackage

// File: rtl/csr_file_irq_sync.sv
// Multi-flop synchronizer bringing one asynchronous level interrupt pin into
// the clk domain. The chain resets to 0 so no spurious interrupt follows reset.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the raw pin through the flop chain; the last flop is the clean level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {SYNC_STAGES{1'b0}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file and trap unit for stage 2 of the 3-stage RV32I pipe.
// Services CSRRW reads/writes, takes timer/external interrupts, executes MRET
// and drives the PC redirect plus the flush of stages 1/2.
module csr_file
  import csr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic            csr_rd,
  input  logic            csr_wr,
  input  logic            is_mret,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] pc_ex,
  input  logic            timer_irq,
  input  logic            ext_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            epc_taken,
  output logic [XLEN-1:0] epc_target,
  output logic            flush
);

  // Architectural state
  state_e          r_state;
  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic            r_mie_mtie;
  logic            r_mie_meie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:2] r_mepc;
  logic [XLEN-1:0] r_mcause;

  // Synchronized interrupt levels (these are the mip bits)
  logic w_mtip;
  logic w_meip;

  // Decode / control
  logic            w_pend_ext;
  logic            w_pend_tmr;
  logic            w_irq_req;
  logic            w_mret_go;
  logic            w_flush_int;
  logic            w_wr_en;
  logic [3:0]      w_cause;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mie;
  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_rdata_sel;
  logic [XLEN-1:0] w_vec_base;
  logic [XLEN-1:0] w_trap_target;

  // pc_ex is word aligned; its low bits never reach mepc
  logic w_unused;
  assign w_unused = &{1'b0, pc_ex[1:0]};

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (timer_irq),
    .o_sync  (w_mtip)
  );

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ext_irq),
    .o_sync  (w_meip)
  );

  // Assemble the read views of mstatus, mie and mip; unimplemented bits are 0
  always_comb begin
    w_mstatus                   = {XLEN{1'b0}};
    w_mstatus[MSTATUS_MIE_BIT]  = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
    w_mie                       = {XLEN{1'b0}};
    w_mie[MIX_MTI_BIT]          = r_mie_mtie;
    w_mie[MIX_MEI_BIT]          = r_mie_meie;
    w_mip                       = {XLEN{1'b0}};
    w_mip[MIX_MTI_BIT]          = w_mtip;
    w_mip[MIX_MEI_BIT]          = w_meip;
  end

  // Interrupt request, cause priority and MRET qualification
  always_comb begin
    w_pend_ext = w_meip & r_mie_meie;
    w_pend_tmr = w_mtip & r_mie_mtie;
    w_irq_req  = r_mstatus_mie & instr_valid & (r_state == RUN) &
                 (w_pend_ext | w_pend_tmr);
    if (w_pend_ext) begin
      w_cause = CAUSE_MEI;
    end else begin
      w_cause = CAUSE_MTI;
    end
    w_mret_go   = is_mret & instr_valid & (r_state == RUN) & ~w_irq_req;
    w_flush_int = w_irq_req | w_mret_go | (r_state == REDIRECT);
    w_wr_en     = csr_wr & instr_valid & ~w_flush_int;
  end

  // Trap vector: direct mode jumps to base, any other mode adds 4*cause
  always_comb begin
    w_vec_base = {r_mtvec[XLEN-1:2], 2'b00};
    if (r_mtvec[1:0] == 2'b00) begin
      w_trap_target = w_vec_base;
    end else begin
      w_trap_target = w_vec_base + {{(XLEN-6){1'b0}}, vec_offset(w_cause)};
    end
  end

  // CSR read mux; unmapped addresses and idle cycles return 0
  always_comb begin
    case (csr_addr)
      CSR_MSTATUS: w_rdata_sel = w_mstatus;
      CSR_MIE:     w_rdata_sel = w_mie;
      CSR_MTVEC:   w_rdata_sel = r_mtvec;
      CSR_MEPC:    w_rdata_sel = {r_mepc, 2'b00};
      CSR_MCAUSE:  w_rdata_sel = r_mcause;
      CSR_MIP:     w_rdata_sel = w_mip;
      default:     w_rdata_sel = {XLEN{1'b0}};
    endcase
    if (csr_rd & instr_valid) begin
      csr_rdata = w_rdata_sel;
    end else begin
      csr_rdata = {XLEN{1'b0}};
    end
  end

  // Redirect outputs; held at 0 while reset is asserted
  always_comb begin
    epc_taken  = rst_n & (w_irq_req | w_mret_go);
    flush      = rst_n & w_flush_int;
    if (!rst_n) begin
      epc_target = {XLEN{1'b0}};
    end else if (w_irq_req) begin
      epc_target = w_trap_target;
    end else if (w_mret_go) begin
      epc_target = {r_mepc, 2'b00};
    end else begin
      epc_target = {XLEN{1'b0}};
    end
  end

  // FSM and CSR update: trap entry > MRET > CSRRW write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mie_meie     <= 1'b0;
      r_mtvec        <= {XLEN{1'b0}};
      r_mepc         <= {(XLEN-2){1'b0}};
      r_mcause       <= {XLEN{1'b0}};
    end else if (w_irq_req) begin
      r_mepc         <= pc_ex[XLEN-1:2];
      r_mcause       <= {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, w_cause};
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
      r_state        <= REDIRECT;
    end else if (w_mret_go) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
      r_state        <= REDIRECT;
    end else begin
      // REDIRECT always lasts exactly one cycle
      r_state <= RUN;
      if (w_wr_en) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= csr_wdata[MSTATUS_MIE_BIT];
            r_mstatus_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
          end
          CSR_MIE: begin
            r_mie_mtie <= csr_wdata[MIX_MTI_BIT];
            r_mie_meie <= csr_wdata[MIX_MEI_BIT];
          end
          CSR_MTVEC:  r_mtvec  <= csr_wdata;
          CSR_MEPC:   r_mepc   <= csr_wdata[XLEN-1:2];
          CSR_MCAUSE: r_mcause <= csr_wdata;
          default: begin
            // mip and unmapped addresses are not writable
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed test of csr_file: CSR access, trap entry (direct and vectored),
// interrupt priority, MRET, write squashing, REDIRECT deferral and async reset.
module tb_csr_file;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        csr_rd;
  logic        csr_wr;
  logic        is_mret;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] pc_ex;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] epc_target;
  logic        flush;

  int n_vec;
  int n_miss;

  csr_file #(.SYNC_STAGES(2), .XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .csr_rd      (csr_rd),
    .csr_wr      (csr_wr),
    .is_mret     (is_mret),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .pc_ex       (pc_ex),
    .timer_irq   (timer_irq),
    .ext_irq     (ext_irq),
    .csr_rdata   (csr_rdata),
    .epc_taken   (epc_taken),
    .epc_target  (epc_target),
    .flush       (flush)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector, reports any miscompare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    instr_valid = 1'b1;
    csr_wr      = 1'b1;
    csr_addr    = addr;
    csr_wdata   = data;
    tick();
    csr_wr      = 1'b0;
    instr_valid = 1'b0;
  endtask

  // Combinational read, checked mid-cycle
  task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    instr_valid = 1'b1;
    csr_rd      = 1'b1;
    csr_addr    = addr;
    #1;
    chk(tag, csr_rdata, exp);
    csr_rd      = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; instr_valid = 1'b0; csr_rd = 1'b0; csr_wr = 1'b0; is_mret = 1'b0;
    csr_addr = 12'h000; csr_wdata = 32'h0; pc_ex = 32'h0; timer_irq = 1'b0; ext_irq = 1'b0;
    tick(); tick();
    chk("rst_flush", {31'd0, flush}, 32'h0);
    chk("rst_taken", {31'd0, epc_taken}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1. reset values, mtvec round trip, read-only/reserved bits
    csr_read("rst_mstatus", 12'h300, 32'h0);
    csr_read("rst_mie",     12'h304, 32'h0);
    csr_read("rst_mtvec",   12'h305, 32'h0);
    csr_read("rst_mepc",    12'h341, 32'h0);
    csr_read("rst_mcause",  12'h342, 32'h0);
    csr_read("rst_mip",     12'h344, 32'h0);
    csr_write(12'h305, 32'h0000_1001);
    csr_read("mtvec_rw", 12'h305, 32'h0000_1001);
    csr_write(12'h344, 32'hFFFF_FFFF);
    csr_read("mip_ro", 12'h344, 32'h0);
    csr_write(12'h300, 32'hFFFF_FFFF);
    csr_read("mstatus_mask", 12'h300, 32'h0000_0088);
    csr_write(12'h300, 32'h0);
    csr_write(12'h7C0, 32'hDEAD_BEEF);
    csr_read("unmapped", 12'h7C0, 32'h0);
    instr_valid = 1'b0;

    // 2. direct-mode timer trap
    csr_write(12'h305, 32'h0000_0100);
    csr_write(12'h304, 32'h0000_0080);
    csr_write(12'h300, 32'h0000_0008);
    instr_valid = 1'b1; pc_ex = 32'h40; timer_irq = 1'b1;
    tick();
    chk("sync_lat_taken", {31'd0, epc_taken}, 32'h0);
    tick();
    chk("t2_taken",  {31'd0, epc_taken}, 32'h1);
    chk("t2_target", epc_target, 32'h0000_0100);
    chk("t2_flush1", {31'd0, flush}, 32'h1);
    tick();
    timer_irq = 1'b0;
    chk("t2_flush2", {31'd0, flush}, 32'h1);
    chk("t2_redir_taken", {31'd0, epc_taken}, 32'h0);
    tick();
    chk("t2_flush_end", {31'd0, flush}, 32'h0);
    csr_read("t2_mepc",    12'h341, 32'h0000_0040);
    csr_read("t2_mcause",  12'h342, 32'h8000_0007);
    csr_read("t2_mstatus", 12'h300, 32'h0000_0080);
    instr_valid = 1'b0;
    tick(); tick(); tick();

    // 3. vectored mode, external beats timer
    csr_write(12'h305, 32'h0000_0201);
    csr_write(12'h304, 32'h0000_0880);
    csr_write(12'h300, 32'h0000_0008);
    instr_valid = 1'b1; pc_ex = 32'h80; timer_irq = 1'b1; ext_irq = 1'b1;
    tick(); tick();
    chk("t3_taken",  {31'd0, epc_taken}, 32'h1);
    chk("t3_target", epc_target, 32'h0000_022C);
    tick();
    timer_irq = 1'b0; ext_irq = 1'b0;
    tick();
    csr_read("t3_mcause", 12'h342, 32'h8000_000B);
    csr_read("t3_mepc",   12'h341, 32'h0000_0080);
    instr_valid = 1'b0;
    tick(); tick(); tick();

    // 4. MRET
    csr_write(12'h341, 32'h0000_0044);
    instr_valid = 1'b1; is_mret = 1'b1;
    #1;
    chk("t4_taken",  {31'd0, epc_taken}, 32'h1);
    chk("t4_target", epc_target, 32'h0000_0044);
    chk("t4_flush",  {31'd0, flush}, 32'h1);
    tick();
    is_mret = 1'b0;
    chk("t4_redir_flush", {31'd0, flush}, 32'h1);
    tick();
    csr_read("t4_mstatus", 12'h300, 32'h0000_0088);
    instr_valid = 1'b0;
    csr_write(12'h300, 32'h0000_0080);
    csr_write(12'h341, 32'h0000_0047);
    csr_read("t4_mepc_lsb", 12'h341, 32'h0000_0044);
    is_mret = 1'b1;
    #1;
    chk("t4b_target", epc_target, 32'h0000_0044);
    tick();
    is_mret = 1'b0;
    tick();
    csr_read("t4b_mstatus", 12'h300, 32'h0000_0088);
    instr_valid = 1'b0;

    // 5. trap squashes a CSRRW; interrupt during REDIRECT is deferred
    timer_irq = 1'b1;
    tick(); tick();
    #1;
    chk("t5_bubble_taken", {31'd0, epc_taken}, 32'h0);
    instr_valid = 1'b1; csr_wr = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h0000_1234; pc_ex = 32'h90;
    #1;
    chk("t5_taken",  {31'd0, epc_taken}, 32'h1);
    chk("t5_target", epc_target, 32'h0000_021C);
    tick();
    csr_wr = 1'b0;
    tick();
    csr_read("t5_mepc", 12'h341, 32'h0000_0090);
    is_mret = 1'b1;
    #1;
    chk("t5_mret_target", epc_target, 32'h0000_0090);
    tick();
    is_mret = 1'b0; pc_ex = 32'h94;
    #1;
    chk("t5_defer_taken", {31'd0, epc_taken}, 32'h0);
    chk("t5_defer_flush", {31'd0, flush}, 32'h1);
    tick();
    chk("t5_retake_taken",  {31'd0, epc_taken}, 32'h1);
    chk("t5_retake_target", epc_target, 32'h0000_021C);
    tick();
    chk("t6_pre_flush", {31'd0, flush}, 32'h1);

    // 6. async reset in REDIRECT
    rst_n = 1'b0;
    #1;
    chk("t6_flush",  {31'd0, flush}, 32'h0);
    chk("t6_taken",  {31'd0, epc_taken}, 32'h0);
    chk("t6_target", epc_target, 32'h0);
    timer_irq = 1'b0;
    tick();
    rst_n = 1'b1;
    csr_read("t6_mstatus", 12'h300, 32'h0);
    csr_read("t6_mie",     12'h304, 32'h0);
    csr_read("t6_mtvec",   12'h305, 32'h0);
    csr_read("t6_mepc",    12'h341, 32'h0);
    csr_read("t6_mcause",  12'h342, 32'h0);
    csr_read("t6_mip",     12'h344, 32'h0);
    chk("t6_post_flush", {31'd0, flush}, 32'h0);
    instr_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
